chu_car_collision_core: RTL
===========================

// Module: chu_car_collision_core
// PURPOSE
// Video-slot stage placed directly upstream of the car-sprite overlay core in the
// pixel stream. It inspects the background/obstacle stream before the car is drawn
// and counts pixels inside the car's bounding box whose colour equals a programmed
// obstacle colour. At each frame end it latches the count and raises a sticky
// collision flag for game-logic software. The pixel stream passes through unchanged.
// PARAMETERS
// CD      12   colour depth of si_rgb/so_rgb and obstacle colour
// CAR_W   32   car bounding-box width, pixels
// CAR_H   64   car bounding-box height, pixels
// HMAX    640  visible pixels per line; last visible x = HMAX-1
// VMAX    480  visible lines per frame; last visible y = VMAX-1
// PORTS
// clk      in   1     system clock
// reset    in   1     synchronous, active-high reset
// x, y     in   11    current pixel coordinate from frame counter
// cs       in   1     slot select
// write    in   1     write strobe (qualified by cs)
// read     in   1     read strobe (qualified by cs; no side effects)
// addr     in   14    register address; only addr[2:0] decoded
// wr_data  in   32    write data
// rd_data  out  32    read data
// si_rgb   in   CD    stream in (background + obstacles)
// so_rgb   out  CD    stream out, to car overlay core
// hit      out  1     sticky collision flag
// BEHAVIOUR
// - so_rgb = si_rgb, combinational, zero latency, in every state including reset.
// - Write map (cs&write): 0 ctrl {bit1 clr, bit0 en}; 1 box_x[10:0]; 2 box_y[10:0];
//   3 obst_rgb[CD-1:0]; 4 thresh[15:0]. clr is a pulse; it is not stored.
// - Read map (combinational on addr[2:0]): 0 {hit_frames[15:0], 14'b0, state==SCAN, hit};
//   1 {16'b0, last_cnt}; 2 {16'b0, thresh}; others 0.
// - Reset values: hit=0, hit_frames=0, last_cnt=0, pix_cnt=0, en=0, box regs=0,
//   thresh=0, obst_rgb=0, state=IDLE.
// - Shadowing: box_x/box_y are copied to active_x/active_y on WAIT_SOF->SCAN; mid-frame
//   writes take effect next frame only.
// - match = (state==SCAN) & (si_rgb==obst_rgb) & x>=ax & x<ax+CAR_W & y>=ay & y<ay+CAR_H;
//   sums computed in 12 bits (no wrap at 2047).
// - pix_cnt 16 bits: increments on edge after a matching pixel; saturates at 0xFFFF.
// - FSM: IDLE   : en=0; pix_cnt held 0. en=1 -> WAIT_SOF (partial frames never counted).
//        WAIT_SOF: on x==0 && y==0 -> SCAN (shadow load; this pixel is evaluated).
//        SCAN   : count; on x==HMAX-1 && y==VMAX-1 -> LATCH (that pixel is counted).
//        LATCH  : one cycle: last_cnt<=pix_cnt; pix_cnt<=0; if thresh!=0 && pix_cnt>=thresh
//                 then hit<=1 and hit_frames+=1 (saturate 0xFFFF); -> WAIT_SOF.
// - en cleared in any state -> IDLE next cycle; pix_cnt cleared; last_cnt/hit/hit_frames kept.
// - clr clears hit and hit_frames; if clr coincides with a LATCH that sets hit, set wins
//   (hit=1, hit_frames=1).
// - thresh=0 disables flagging; last_cnt still updates.
// - reset mid-frame returns everything to reset values in one cycle; counting restarts
//   only after en is rewritten and a fresh start-of-frame is seen.
// TESTING
// - Reset, then drive 2 frames with en=0 -> so_rgb==si_rgb each pixel; hit=0, last_cnt=0.
// - en=1 mid-frame; box (100,200); obst=0xF00; 50 red pixels in box -> first partial frame
//   ignored; next frame last_cnt=50.
// - thresh=50, 50 red pixels in box -> hit=1, hit_frames=1 after LATCH; red outside box not counted.
// - thresh=51, 50 red pixels -> hit stays 0; clr in LATCH cycle with a hit -> hit=1, hit_frames=1.
// - box_x rewritten to 300 mid-frame -> current frame uses 100, next uses 300.
// - Box at (2040,2040) -> no wrap, count 0; force >65535 matches -> last_cnt=0xFFFF.

Source files
------------

// File: rtl/chu_car_collision_core.sv
// Car collision detector for a video slot.
// It sits in front of the car overlay and counts obstacle-coloured pixels inside
// the car's bounding box. At each frame end it latches the count and can raise
// a sticky hit flag. The pixel stream passes through unchanged.
module chu_car_collision_core #(
  parameter int CD    = 12,
  parameter int CAR_W = 32,
  parameter int CAR_H = 64,
  parameter int HMAX  = 640,
  parameter int VMAX  = 480
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic          read,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb,
  output logic          hit
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    SCAN     = 2'd2,
    LATCH    = 2'd3
  } state_t;

  localparam logic [10:0] X_LAST = 11'(HMAX - 1);
  localparam logic [10:0] Y_LAST = 11'(VMAX - 1);
  // Box edges are summed in 12 bits so a box near 2047 never wraps to small coordinates.
  localparam logic [11:0] BOX_W  = 12'(CAR_W);
  localparam logic [11:0] BOX_H  = 12'(CAR_H);

  // Saturating 16-bit increment shared by the pixel and frame counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return 16'hFFFF;
    end else begin
      return v + 16'd1;
    end
  endfunction

  state_t        state_r;
  logic          en_r;
  logic [10:0]   box_x_r;
  logic [10:0]   box_y_r;
  logic [10:0]   active_x_r;
  logic [10:0]   active_y_r;
  logic [CD-1:0] obst_rgb_r;
  logic [15:0]   thresh_r;
  logic [15:0]   pix_cnt_r;
  logic [15:0]   last_cnt_r;
  logic [15:0]   hit_frames_r;
  logic          hit_r;

  logic          wr_s;
  logic          ctrl_wr_s;
  logic          clr_s;
  logic          en_next_s;
  logic          sof_s;
  logic          eof_s;
  logic          load_s;
  logic [10:0]   win_x_s;
  logic [10:0]   win_y_s;
  logic [11:0]   x_lo_s;
  logic [11:0]   x_hi_s;
  logic [11:0]   y_lo_s;
  logic [11:0]   y_hi_s;
  logic          in_box_s;
  logic          match_s;
  logic          hit_set_s;
  logic          hit_next_s;
  logic [15:0]   hf_base_s;
  logic [15:0]   hf_next_s;
  logic          unused_s;

  assign so_rgb    = si_rgb;
  assign hit       = hit_r;

  assign wr_s      = cs & write;
  assign ctrl_wr_s = wr_s && (addr[2:0] == 3'd0);
  assign clr_s     = ctrl_wr_s & wr_data[1];
  // The state machine reacts to an enable write at the same edge it is stored.
  assign en_next_s = ctrl_wr_s ? wr_data[0] : en_r;

  assign sof_s     = (x == 11'd0) && (y == 11'd0);
  assign eof_s     = (x == X_LAST) && (y == Y_LAST);
  assign load_s    = (state_r == WAIT_SOF) && sof_s;

  // Select the box origin: the shadow copy while scanning, the live registers at start of frame.
  always_comb begin
    if (state_r == SCAN) begin
      win_x_s = active_x_r;
      win_y_s = active_y_r;
    end else begin
      win_x_s = box_x_r;
      win_y_s = box_y_r;
    end
  end

  assign x_lo_s    = {1'b0, win_x_s};
  assign x_hi_s    = x_lo_s + BOX_W;
  assign y_lo_s    = {1'b0, win_y_s};
  assign y_hi_s    = y_lo_s + BOX_H;
  assign in_box_s  = ({1'b0, x} >= x_lo_s) && ({1'b0, x} < x_hi_s) &&
                     ({1'b0, y} >= y_lo_s) && ({1'b0, y} < y_hi_s);
  assign match_s   = ((state_r == SCAN) || load_s) && (si_rgb == obst_rgb_r) && in_box_s;
  assign hit_set_s = (state_r == LATCH) && en_next_s && (thresh_r != 16'd0) &&
                     (pix_cnt_r >= thresh_r);

  // Resolve clear against frame-end flagging; setting wins and counts from the cleared value.
  always_comb begin
    if (clr_s) begin
      hf_base_s = 16'd0;
    end else begin
      hf_base_s = hit_frames_r;
    end
    if (hit_set_s) begin
      hit_next_s = 1'b1;
      hf_next_s  = sat_inc16(hf_base_s);
    end else begin
      hit_next_s = hit_r & ~clr_s;
      hf_next_s  = hf_base_s;
    end
  end

  // Software-visible configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_r       <= 1'b0;
      box_x_r    <= 11'd0;
      box_y_r    <= 11'd0;
      obst_rgb_r <= '0;
      thresh_r   <= 16'd0;
    end else if (wr_s) begin
      case (addr[2:0])
        3'd0:    en_r       <= wr_data[0];
        3'd1:    box_x_r    <= wr_data[10:0];
        3'd2:    box_y_r    <= wr_data[10:0];
        3'd3:    obst_rgb_r <= wr_data[CD-1:0];
        3'd4:    thresh_r   <= wr_data[15:0];
        default: ;
      endcase
    end
  end

  // Frame state machine with pixel counting, frame-end latch and sticky hit tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      pix_cnt_r    <= 16'd0;
      last_cnt_r   <= 16'd0;
      hit_r        <= 1'b0;
      hit_frames_r <= 16'd0;
      active_x_r   <= 11'd0;
      active_y_r   <= 11'd0;
    end else begin
      hit_r        <= hit_next_s;
      hit_frames_r <= hf_next_s;
      if (!en_next_s) begin
        state_r   <= IDLE;
        pix_cnt_r <= 16'd0;
      end else begin
        case (state_r)
          IDLE: begin
            pix_cnt_r <= 16'd0;
            state_r   <= WAIT_SOF;
          end
          WAIT_SOF: begin
            if (sof_s) begin
              active_x_r <= box_x_r;
              active_y_r <= box_y_r;
              pix_cnt_r  <= match_s ? 16'd1 : 16'd0;
              state_r    <= SCAN;
            end
          end
          SCAN: begin
            if (match_s) begin
              pix_cnt_r <= sat_inc16(pix_cnt_r);
            end
            if (eof_s) begin
              state_r <= LATCH;
            end
          end
          LATCH: begin
            last_cnt_r <= pix_cnt_r;
            pix_cnt_r  <= 16'd0;
            state_r    <= WAIT_SOF;
          end
          default: begin
            pix_cnt_r <= 16'd0;
            state_r   <= IDLE;
          end
        endcase
      end
    end
  end

  // Read mux; reads have no side effects.
  always_comb begin
    case (addr[2:0])
      3'd0:    rd_data = {hit_frames_r, 14'd0, (state_r == SCAN), hit_r};
      3'd1:    rd_data = {16'd0, last_cnt_r};
      3'd2:    rd_data = {16'd0, thresh_r};
      default: rd_data = 32'd0;
    endcase
  end

  assign unused_s = ^{read, addr[13:3], wr_data[31:16]};

endmodule
